// File: rtl/button_conditioner_if.sv
// button_conditioner_if
//   Bundles the raw front-panel inputs and the conditioned outputs of
//   button_conditioner.
//   buttonRaw   [N_BTN]   bouncy push-button levels (asynchronous)
//   switchRaw   [DATA_W]  slide-switch bus (asynchronous)
//   buttonPulse [N_BTN]   one-cycle strobe per qualified press
//   buttonLevel [N_BTN]   debounced button level
//   dataOut     [DATA_W]  switch value captured with a strobe
//   master: drives raw inputs (board / bench); slave: the conditioner.
interface button_conditioner_if #(
  parameter int N_BTN  = 3,
  parameter int DATA_W = 4
);
  logic [N_BTN-1:0]  buttonRaw;
  logic [DATA_W-1:0] switchRaw;
  logic [N_BTN-1:0]  buttonPulse;
  logic [N_BTN-1:0]  buttonLevel;
  logic [DATA_W-1:0] dataOut;

  modport master (
    output buttonRaw, switchRaw,
    input  buttonPulse, buttonLevel, dataOut
  );

  modport slave (
    input  buttonRaw, switchRaw,
    output buttonPulse, buttonLevel, dataOut
  );
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner
//   Synchronizes and debounces N_BTN push buttons and captures the switch
//   bus whenever any button qualifies a press.
//   clockCustom  system clock, rising edge
//   resetGral    synchronous active-high reset
//   bus          button_conditioner_if.slave (raw inputs in, strobes,
//                levels and captured switch data out)

// One debounce channel: LOW -> RISE -> HIGH -> FALL with a shared counter.
module button_debounce_lane #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 5
) (
  input  logic clockCustom,
  input  logic resetGral,
  input  logic synced,
  output logic pulseSet,   // combinational: pulse registers on this edge
  output logic pulse,
  output logic level
);
  typedef enum logic [1:0] {LOW, RISE, HIGH, FALL} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             levelNext;

  always_ff @(posedge clockCustom) begin
    if (resetGral) begin
      state <= LOW;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      pulse <= pulseSet;
      level <= levelNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    pulseSet  = 1'b0;
    case (state)
      LOW:  if (synced) begin stateNext = RISE; cntNext = '0; end
      RISE: begin
        if (!synced) begin
          stateNext = LOW;
          cntNext   = '0;
        end else if (cnt == LAST) begin
          stateNext = HIGH;
          cntNext   = '0;
          pulseSet  = 1'b1;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      HIGH: if (!synced) begin stateNext = FALL; cntNext = '0; end
      FALL: begin
        // Bounce back high is a continuation of the same press: no pulse.
        if (synced) begin
          stateNext = HIGH;
          cntNext   = '0;
        end else if (cnt == LAST) begin
          stateNext = LOW;
          cntNext   = '0;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      default: begin stateNext = LOW; cntNext = '0; end
    endcase
  end

  // Level decoded from the next state so the register moves with the FSM.
  always_comb begin
    levelNext = (stateNext == HIGH) || (stateNext == FALL);
  end
endmodule

module button_conditioner #(
  parameter int N_BTN     = 3,
  parameter int DATA_W    = 4,
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 5
) (
  input  logic clockCustom,
  input  logic resetGral,
  button_conditioner_if.slave bus
);
  logic [N_BTN-1:0]  btnSync1, btnSync2;
  logic [DATA_W-1:0] swSync1, swSync2;
  logic [N_BTN-1:0]  pulseSet, pulseQ, levelQ;
  logic [DATA_W-1:0] dataQ;

  always_ff @(posedge clockCustom) begin
    if (resetGral) begin
      btnSync1 <= '0;
      btnSync2 <= '0;
      swSync1  <= '0;
      swSync2  <= '0;
      dataQ    <= '0;
    end else begin
      btnSync1 <= bus.buttonRaw;
      btnSync2 <= btnSync1;
      swSync1  <= bus.switchRaw;
      swSync2  <= swSync1;
      // One capture even when several channels qualify together.
      if (|pulseSet) dataQ <= swSync2;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    button_debounce_lane #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_lane (
      .clockCustom (clockCustom),
      .resetGral   (resetGral),
      .synced      (btnSync2[i]),
      .pulseSet    (pulseSet[i]),
      .pulse       (pulseQ[i]),
      .level       (levelQ[i])
    );
  end

  assign bus.buttonPulse = pulseQ;
  assign bus.buttonLevel = levelQ;
  assign bus.dataOut     = dataQ;
endmodule
